// File: rtl/mem_arbiter_pkg.sv
// =====================================================================
// mem_arb_pkg: shared types and constants for the memory arbiter.
// Rev 1.0
// =====================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_IC = 1'b0,
        GRANT_DC = 1'b1
    } grant_t;

    localparam logic [3:0] LINE_OFFSET_MASK = 4'hF;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// =====================================================================
// mem_arbiter_if: cache request, response and memory port bundle.
// Rev 1.0
// =====================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int cache_line_width = 256,
    parameter int addr_width       = 16
);
    logic                        icPetition;
    logic [addr_width-1:0]       icAddr;
    logic                        dcPetition;
    logic [addr_width-1:0]       dcAddr;
    logic                        dcWrite;
    logic [cache_line_width-1:0] dcWriteData;
    logic                        icServiceReady;
    logic                        dcServiceReady;
    logic [cache_line_width-1:0] lineReadFromMem;
    logic [addr_width-1:0]       memAddr;
    logic                        memRead;
    logic                        memWrite;
    logic [cache_line_width-1:0] memWriteData;
    logic [cache_line_width-1:0] memReadData;
    logic                        busy;

    // Arbiter view.
    modport master (
        input  icPetition, icAddr, dcPetition, dcAddr, dcWrite, dcWriteData, memReadData,
        output icServiceReady, dcServiceReady, lineReadFromMem, memAddr,
               memRead, memWrite, memWriteData, busy
    );

    // Caches and memory view.
    modport slave (
        output icPetition, icAddr, dcPetition, dcAddr, dcWrite, dcWriteData, memReadData,
        input  icServiceReady, dcServiceReady, lineReadFromMem, memAddr,
               memRead, memWrite, memWriteData, busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter_latency_counter.sv
// =====================================================================
// mem_latency_counter: loadable down-counter that saturates at zero.
// Rev 1.0
// =====================================================================
`default_nettype none

module mem_latency_counter #(
    parameter int WIDTH = 3
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             load_i,
    input  wire logic [WIDTH-1:0] load_val_i,
    input  wire logic             dec_i,
    output logic                  zero_o
);
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// =====================================================================
// mem_arbiter: grants the memory port to the I- or D-cache and runs a
// fixed-latency line read or write-back. Rev 1.0
// =====================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int cache_line_width = 256,
    parameter int addr_width       = 16,
    parameter int mem_latency      = 5
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(mem_latency + 1);
    localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(mem_latency - 1);
    localparam logic [addr_width-1:0] ADDR_MASK = {{(addr_width-4){1'b0}}, LINE_OFFSET_MASK};

    state_t                      state_q, state_d;
    grant_t                      grant_q, grant_d;
    grant_t                      last_grant_q, last_grant_d;
    grant_t                      pick;
    logic [addr_width-1:0]       addr_q, addr_d;
    logic                        write_q, write_d;
    logic [cache_line_width-1:0] wdata_q, wdata_d;
    logic [cache_line_width-1:0] line_q, line_d;
    logic                        cnt_load, cnt_dec, cnt_zero;

    mem_latency_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (cnt_load),
        .load_val_i (CNT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // On a tie the requester that was not served last time wins.
    always_comb begin
        if (bus.icPetition && bus.dcPetition) begin
            pick = (last_grant_q == GRANT_IC) ? GRANT_DC : GRANT_IC;
        end else if (bus.dcPetition) begin
            pick = GRANT_DC;
        end else begin
            pick = GRANT_IC;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= GRANT_IC;
            last_grant_q <= GRANT_IC;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            line_q       <= line_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        last_grant_d       = last_grant_q;
        addr_d             = addr_q;
        write_d            = write_q;
        wdata_d            = wdata_q;
        line_d             = line_q;
        cnt_load           = 1'b0;
        cnt_dec            = 1'b0;
        bus.memAddr        = '0;
        bus.memRead        = 1'b0;
        bus.memWrite       = 1'b0;
        bus.memWriteData   = '0;
        bus.icServiceReady = 1'b0;
        bus.dcServiceReady = 1'b0;
        bus.busy           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.icPetition || bus.dcPetition) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    cnt_load     = 1'b1;
                    state_d      = ST_ACCESS;
                    if (pick == GRANT_DC) begin
                        addr_d  = bus.dcAddr & ~ADDR_MASK;
                        write_d = bus.dcWrite;
                        wdata_d = bus.dcWriteData;
                    end else begin
                        addr_d  = bus.icAddr & ~ADDR_MASK;
                        write_d = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                bus.busy     = 1'b1;
                bus.memAddr  = addr_q;
                bus.memRead  = !write_q;
                bus.memWrite = write_q;
                if (write_q) begin
                    bus.memWriteData = wdata_q;
                end
                if (cnt_zero) begin
                    if (!write_q) begin
                        line_d = bus.memReadData;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RESP: begin
                // Petitions are still up here until the requester sees its hit.
                bus.busy           = 1'b1;
                bus.icServiceReady = (grant_q == GRANT_IC);
                bus.dcServiceReady = (grant_q == GRANT_DC);
                state_d            = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.lineReadFromMem = line_q;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single main-memory port between the instruction cache and the data cache and sequences each fixed-latency memory transaction. It sits directly upstream of the instruction cache: it consumes the cache's petition and address, and produces the one-cycle service-ready pulse and the 256-bit line that the cache writes into its data lines. The data cache side is symmetric, with an added line write-back (write) path.

## Interface
- `cache_line_width`, default 256: line width in bits; this is also the memory data width.
- `addr_width`, default 16: word-address width.
- `mem_latency`, default 5: number of cycles memory needs per access. Must be ≥ 1.
- `clk` in 1: the single clock; all state is updated on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `icPetition` in 1: instruction-cache miss request; held high until served.
- `icAddr` in `addr_width`: instruction-cache miss address.
- `dcPetition` in 1: data-cache request; held high until served.
- `dcAddr` in `addr_width`: data-cache address.
- `dcWrite` in 1: 1 = line write-back, 0 = line fill.
- `dcWriteData` in `cache_line_width`: line to write back.
- `icServiceReady` out 1: one-cycle completion pulse to the instruction cache.
- `dcServiceReady` out 1: one-cycle completion pulse to the data cache.
- `lineReadFromMem` out `cache_line_width`: registered fill line, shared by both caches.
- `memAddr` out `addr_width`: line-aligned memory address.
- `memRead` out 1 / `memWrite` out 1: memory command, held for the whole access.
- `memWriteData` out `cache_line_width`: write-back data to memory.
- `memReadData` in `cache_line_width`: memory read data, valid in the last access cycle.
- `busy` out 1: high in every state except IDLE.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP.
- **IDLE**
  - Samples both petitions on every edge.
  - If exactly one petition is high, that requester is granted.
  - If both are high, the requester not granted last time wins, tracked by a `lastGrant` register.
  - On a grant:
    - latch the winner's address with bits [3:0] cleared (line-aligned);
    - for the data cache, latch `dcWrite` and `dcWriteData`;
    - load the counter with `mem_latency`-1 and go to ACCESS.
- **ACCESS**
  - `memAddr` shows the latched address.
  - `memRead` = !write and `memWrite` = write, both held stable throughout the state.
  - The counter decrements every cycle. In the cycle the counter reads 0:
    - for a read, `memReadData` is captured into the line register;
    - the FSM moves to RESP.
- **RESP**
  - Exactly one cycle.
  - The granted requester's ServiceReady is high; the other requester's stays low.
  - Memory commands are low.
  - Petitions are ignored in this cycle, because the requester still shows its petition until its hit registers.
  - Next state is IDLE.
- **Line register**
  - Holds its value until the next read capture.
  - Write-backs never modify it.
- **Dropped petition**: if the petition falls during ACCESS (e.g. a fetch redirect), the transaction still completes and the ready pulse is still issued. The requester gates the pulse with its own petition.
- **Outputs in IDLE**: all memory commands and ready pulses are 0, and `memAddr` = 0.

## Timing
- **Reset**
  - Asynchronous assertion forces IDLE, including in the middle of a transaction.
  - All outputs go to 0, the line register is cleared, and `lastGrant` = icache, so the first tie goes to the data cache.
  - An aborted memory access is not resumed.
- **Latency**: a petition sampled high in IDLE at edge t0 gives `memRead`/`memWrite` high in cycles t0+1 … t0+`mem_latency`. The ready pulse and valid `lineReadFromMem` follow in cycle t0+`mem_latency`+1.
- **Throughput**: back-to-back service is `mem_latency`+2 cycles per transaction (IDLE, ACCESS×`mem_latency`, RESP).
- **`mem_latency` = 1**: ACCESS lasts exactly one cycle.
- **Counter width**: `$clog2(mem_latency+1)`; the counter never wraps.
- **Tie**: when both petitions are high in the same IDLE cycle, exactly one is granted. The loser stays pending and is granted in the following IDLE cycle.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the grant enum (GRANT_IC, GRANT_DC);
  - the line-offset mask constant (low 4 bits).
- One sub-module, `mem_latency_counter`:
  - loadable down-counter with load, decrement and a zero flag;
  - asynchronous active-low reset.
- The FSM, latches and output logic stay in `mem_arbiter`.

## Test plan
- **IC fill**: `icPetition` = 1, `icAddr` = 0x1237, `mem_latency` = 5.
  - `memAddr` = 0x1230 and `memRead` high for 5 cycles.
  - `icServiceReady` pulses 1 cycle at t0+6 with `lineReadFromMem` = the memory pattern.
- **DC write-back**: `dcWrite` = 1, data = 0xA5…A5.
  - `memWrite` high for 5 cycles with `memWriteData` = 0xA5…A5.
  - `dcServiceReady` pulses and `lineReadFromMem` is unchanged.
- **Tie after reset**: both petitions high.
  - The data cache is served first, then the instruction cache starting in the next IDLE cycle.
  - A second tie is granted to the data cache again (alternation).
- **Held petition during RESP**: petition still high in the RESP cycle.
  - No new grant in RESP; `busy` falls in the next cycle.
- **Reset mid-ACCESS**: assert `reset` low at the third ACCESS cycle.
  - All outputs 0 immediately, with no ready pulse.
  - After release, a new petition is served from IDLE with full latency.
- **Dropped petition**: `icPetition` falls during ACCESS.
  - `icServiceReady` still pulses at t0+`mem_latency`+1.
